mem_store_packer: RTL and testbench
===================================

# mem_store_packer

Store-side front end for the shared vector memory. It accepts a store request (base address, element count) and a one-element-per-cycle data stream, and packs the elements into contiguous blocks of up to BLOCK_SIZE elements. It then drives the memory's block write port (address, packed data, write size, write enable) directly. It sits between the SIMD core's store path and the memory's write side; the memory's read side is untouched.

## Interface
- SIZE, 32, element width in bits
- BLOCK_SIZE, 5, max elements per memory write
- ADDR_SIZE, 24, element address width
- LEN_SIZE, 16, request length width (elements)
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_req_valid  in  1  store request valid
- o_req_ready  out  1  block idle, request accepted when valid&ready
- i_req_addr  in  ADDR_SIZE  first element address
- i_req_len  in  LEN_SIZE  element count; 0 is legal
- i_elem_valid  in  1  element valid
- o_elem_ready  out  1  element accepted when valid&ready
- i_elem_data  in  SIZE  element
- o_addr_w  out  ADDR_SIZE  write base address
- o_data_w  out  SIZE*BLOCK_SIZE  packed block; element k at bits [(BLOCK_SIZE-k)*SIZE-1 -: SIZE]
- o_wr_size  out  $clog2(BLOCK_SIZE)+1  elements valid in this write, 1..BLOCK_SIZE
- o_wr_en  out  1  write strobe, one cycle per block
- o_busy  out  1  request in progress (state != IDLE)
- o_done  out  1  one-cycle pulse, request complete

## Operation
- States: IDLE, FILL, DONE.
- IDLE: o_req_ready=1. On accept, latch addr and len, clear fill count.
  - len!=0 -> FILL.
  - len==0 -> DONE with no write.
- FILL: o_elem_ready=1. Each accepted element goes into pack slot `fill`, and remaining decrements.
  - Block is complete when fill reaches BLOCK_SIZE, or when remaining reaches 0 (partial tail).
  - On block completion, the pack buffer transfers to the output registers and a write issues the next cycle:
    - o_addr_w = current block address.
    - o_wr_size = fill.
    - Slots >= fill are zero.
  - Block address then advances by BLOCK_SIZE, modulo 2^ADDR_SIZE (wrap, no error). Fill returns to 0.
  - The accept that ends the request -> DONE.
- DONE: o_done=1 for exactly one cycle. For len!=0, this is the same cycle as the final o_wr_en. Next state IDLE.
- Write-side outputs are registered, separate from the pack buffer. Packing continues at one element per cycle while the previous block is being written, so there are no bubbles.
- Gaps in i_elem_valid stall packing only; a partial block is never flushed early.
- Pack-slot order is fixed: the lowest address element occupies the most-significant slice, matching the memory write port.
- Reset (any time, including mid-request): state IDLE, pack buffer and fill cleared, no write issued, partial data discarded.

## Timing
- Reset values:
  - o_req_ready=1, o_elem_ready=0, o_busy=0, o_done=0.
  - o_wr_en=0, o_wr_size=0, o_addr_w=0, o_data_w=0.
- Request accept at cycle t -> o_elem_ready=1 from t+1 (len!=0), or o_done=1 at t+1 (len==0).
- Element that completes a block, accepted at cycle c -> o_wr_en=1 at c+1, for exactly one cycle.
- Back-to-back full throughput: len=N takes ceil(N/BLOCK_SIZE) writes, with the last write at (accept of element N)+1.
- o_req_ready returns at done+1. Minimum request-to-request spacing is len+2 cycles.
- o_done never coincides with o_req_ready.

## Structure
- Shared package mem_pkg holds:
  - typedef enum store_state_e {IDLE, FILL, DONE}.
  - Localparam helper WR_SIZE_W = $clog2(BLOCK_SIZE)+1, shared with the memory's write-size port.
- Single module; no sub-module is warranted. The pack buffer and output register stay inline.

## Test plan
- Full blocks: addr=0x10, len=10, data 1..10 every cycle -> two writes:
  - addr 0x10, size 5, data 1,2,3,4,5 (MSB first).
  - addr 0x15, size 5, data 6..10.
  - o_done coincides with the second write.
- Partial tail: addr=0x20, len=7 -> writes (0x20, size 5) and (0x25, size 2, slices 2..4 zero). Readback via the memory's read port matches at 0x20..0x26.
- len=0 -> o_done one cycle after accept, no o_wr_en, o_req_ready back next cycle.
- Stalled stream: len=5 with i_elem_valid toggling 1010... -> a single write 1 cycle after the 5th accept, no early flush.
- Wrap: addr=2^24-3, len=5 -> write at 0xFFFFFD, size 5. The next request with addr=2^24-2, len=8 gives writes at 0xFFFFFE and 0x000003.
- Reset mid-request: assert i_rst_n=0 after 3 of 5 elements -> no write ever issued, outputs at reset values, a new request is accepted normally after release.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and sizing helpers for the vector memory store path
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } store_state_e;

    localparam int BLOCK_SIZE_DEFAULT = 5;

    // Width of the memory's write-size port; must hold the value BLOCK_SIZE itself.
    localparam int WR_SIZE_W = $clog2(BLOCK_SIZE_DEFAULT) + 1;

    function automatic int wr_size_w(input int block_size);
        return $clog2(block_size) + 1;
    endfunction

endpackage

// File: rtl/mem_store_packer.sv
// rtl/mem_store_packer.sv - packs a store element stream into block writes for the vector memory
module mem_store_packer
    import mem_pkg::*;
#(
    parameter int SIZE       = 32,
    parameter int BLOCK_SIZE = 5,
    parameter int ADDR_SIZE  = 24,
    parameter int LEN_SIZE   = 16
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_req_valid,
    output logic                            o_req_ready,
    input  logic [ADDR_SIZE-1:0]            i_req_addr,
    input  logic [LEN_SIZE-1:0]             i_req_len,
    input  logic                            i_elem_valid,
    output logic                            o_elem_ready,
    input  logic [SIZE-1:0]                 i_elem_data,
    output logic [ADDR_SIZE-1:0]            o_addr_w,
    output logic [SIZE*BLOCK_SIZE-1:0]      o_data_w,
    output logic [$clog2(BLOCK_SIZE):0]     o_wr_size,
    output logic                            o_wr_en,
    output logic                            o_busy,
    output logic                            o_done
);

    localparam int WS_W = $clog2(BLOCK_SIZE) + 1;

    store_state_e               state_q, state_d;
    logic [ADDR_SIZE-1:0]       blk_addr_q, blk_addr_d;
    logic [LEN_SIZE-1:0]        rem_q, rem_d;
    logic [WS_W-1:0]            fill_q, fill_d;
    logic [SIZE-1:0]            pack_q [BLOCK_SIZE];
    logic [SIZE-1:0]            pack_d [BLOCK_SIZE];
    logic [SIZE-1:0]            pack_next [BLOCK_SIZE];

    logic [ADDR_SIZE-1:0]       addr_w_q, addr_w_d;
    logic [SIZE*BLOCK_SIZE-1:0] data_w_q, data_w_d;
    logic [WS_W-1:0]            wr_size_q, wr_size_d;
    logic                       wr_en_q, wr_en_d;

    logic                       req_last;
    logic                       blk_last;

    always_comb begin
        state_d      = state_q;
        blk_addr_d   = blk_addr_q;
        rem_d        = rem_q;
        fill_d       = fill_q;
        pack_d       = pack_q;
        addr_w_d     = addr_w_q;
        data_w_d     = data_w_q;
        wr_size_d    = wr_size_q;
        wr_en_d      = 1'b0;
        o_req_ready  = 1'b0;
        o_elem_ready = 1'b0;

        // Pack buffer as it would look with the incoming element placed in slot fill.
        pack_next = pack_q;
        for (int k = 0; k < BLOCK_SIZE; k++) begin
            if (WS_W'(k) == fill_q) begin
                pack_next[k] = i_elem_data;
            end
        end

        req_last = (rem_q == LEN_SIZE'(1));
        blk_last = (fill_q == WS_W'(BLOCK_SIZE - 1)) || req_last;

        case (state_q)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    blk_addr_d = i_req_addr;
                    rem_d      = i_req_len;
                    fill_d     = '0;
                    state_d    = (i_req_len == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                o_elem_ready = 1'b1;
                if (i_elem_valid) begin
                    rem_d = rem_q - 1'b1;
                    if (blk_last) begin
                        // Unused slots are already zero: the buffer is cleared after every block.
                        wr_en_d   = 1'b1;
                        addr_w_d  = blk_addr_q;
                        wr_size_d = fill_q + 1'b1;
                        for (int k = 0; k < BLOCK_SIZE; k++) begin
                            data_w_d[(BLOCK_SIZE-k)*SIZE-1 -: SIZE] = pack_next[k];
                            pack_d[k] = '0;
                        end
                        fill_d     = '0;
                        blk_addr_d = blk_addr_q + ADDR_SIZE'(BLOCK_SIZE);
                        if (req_last) begin
                            state_d = DONE;
                        end
                    end else begin
                        pack_d = pack_next;
                        fill_d = fill_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            blk_addr_q <= '0;
            rem_q      <= '0;
            fill_q     <= '0;
            for (int k = 0; k < BLOCK_SIZE; k++) begin
                pack_q[k] <= '0;
            end
            addr_w_q   <= '0;
            data_w_q   <= '0;
            wr_size_q  <= '0;
            wr_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            blk_addr_q <= blk_addr_d;
            rem_q      <= rem_d;
            fill_q     <= fill_d;
            pack_q     <= pack_d;
            addr_w_q   <= addr_w_d;
            data_w_q   <= data_w_d;
            wr_size_q  <= wr_size_d;
            wr_en_q    <= wr_en_d;
        end
    end

    assign o_addr_w  = addr_w_q;
    assign o_data_w  = data_w_q;
    assign o_wr_size = wr_size_q;
    assign o_wr_en   = wr_en_q;
    assign o_busy    = (state_q != IDLE);
    assign o_done    = (state_q == DONE);

endmodule

// File: tb/tb_mem_store_packer.sv
// tb/tb_mem_store_packer.sv - randomized self-checking bench for mem_store_packer
module tb_mem_store_packer;

    localparam int SIZE = 32;
    localparam int BS   = 5;
    localparam int AW   = 24;
    localparam int LW   = 16;
    localparam int WSW  = $clog2(BS) + 1;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              i_req_valid = 1'b0;
    logic              o_req_ready;
    logic [AW-1:0]     i_req_addr = '0;
    logic [LW-1:0]     i_req_len = '0;
    logic              i_elem_valid = 1'b0;
    logic              o_elem_ready;
    logic [SIZE-1:0]   i_elem_data = '0;
    logic [AW-1:0]     o_addr_w;
    logic [SIZE*BS-1:0] o_data_w;
    logic [WSW-1:0]    o_wr_size;
    logic              o_wr_en;
    logic              o_busy;
    logic              o_done;

    mem_store_packer #(.SIZE(SIZE), .BLOCK_SIZE(BS), .ADDR_SIZE(AW), .LEN_SIZE(LW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_addr(i_req_addr), .i_req_len(i_req_len),
        .i_elem_valid(i_elem_valid), .o_elem_ready(o_elem_ready), .i_elem_data(i_elem_data),
        .o_addr_w(o_addr_w), .o_data_w(o_data_w), .o_wr_size(o_wr_size), .o_wr_en(o_wr_en),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_req_cyc = 0;

    always @(posedge i_clk) cyc = cyc + 1;

    typedef struct {
        int                 cyc;
        logic [AW-1:0]      addr;
        int                 size;
        logic [SIZE*BS-1:0] data;
    } wr_t;

    wr_t             wr_log[$];
    logic [SIZE-1:0] mem [int];
    logic [SIZE-1:0] elems[$];

    // Behavioural memory write port plus a log of every write seen.
    always @(negedge i_clk) begin
        if (o_wr_en === 1'b1) begin
            wr_t w;
            w.cyc  = cyc;
            w.addr = o_addr_w;
            w.size = int'(o_wr_size);
            w.data = o_data_w;
            wr_log.push_back(w);
            for (int k = 0; k < int'(o_wr_size) && k < BS; k++) begin
                mem[(int'(o_addr_w) + k) % (1 << AW)] = o_data_w[(BS-k)*SIZE-1 -: SIZE];
            end
        end
    end

    task automatic fill_random(input int len);
        elems.delete();
        for (int i = 0; i < len; i++) elems.push_back($urandom);
    endtask

    // Called at a negedge; returns at the negedge after o_done (where o_req_ready must be back).
    // mode: 0 continuous, 1 toggling 1010..., 2 random gaps.
    task automatic do_request(input logic [AW-1:0] addr, input int len, input int mode, input string name);
        int acc_cyc[$];
        int t_req, n, guard, phase, nb, sz, exp_done;
        logic v;
        logic [AW-1:0] exp_addr;
        logic [SIZE*BS-1:0] exp_data;
        wr_log.delete();
        guard = 0;
        while (o_req_ready !== 1'b1 && guard < 50) begin
            @(negedge i_clk);
            guard++;
        end
        checks++;
        if (o_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s req_ready: got %b want 1", name, o_req_ready);
        end
        i_req_valid = 1'b1;
        i_req_addr  = addr;
        i_req_len   = LW'(len);
        t_req = cyc;
        last_req_cyc = t_req;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        n = 0; guard = 0; phase = 0;
        while (n < len && guard < 2000) begin
            if (mode == 0) v = 1'b1;
            else if (mode == 1) v = (phase % 2 == 0);
            else v = ($urandom_range(0, 2) != 0);
            phase++;
            i_elem_valid = v;
            i_elem_data  = elems[n];
            if (v && o_elem_ready === 1'b1) begin
                acc_cyc.push_back(cyc);
                n++;
            end
            @(negedge i_clk);
            guard++;
        end
        i_elem_valid = 1'b0;
        checks++;
        if (n != len) begin
            errors++;
            $display("FAIL %s elements accepted: got %0d want %0d", name, n, len);
        end
        if (mode == 0) begin
            for (int i = 0; i < acc_cyc.size(); i++) begin
                checks++;
                if (acc_cyc[i] != t_req + 1 + i) begin
                    errors++;
                    $display("FAIL %s elem %0d accept cycle: got %0d want %0d", name, i, acc_cyc[i], t_req + 1 + i);
                end
            end
        end
        exp_done = (len == 0) ? t_req + 1 : acc_cyc[acc_cyc.size()-1] + 1;
        checks++;
        if (cyc != exp_done || o_done !== 1'b1 || o_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s done: cyc %0d done %b ready %b want cyc %0d done 1 ready 0",
                     name, cyc, o_done, o_req_ready, exp_done);
        end
        @(negedge i_clk);
        checks++;
        if (o_done !== 1'b0 || o_req_ready !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after done: done %b ready %b busy %b want 0 1 0", name, o_done, o_req_ready, o_busy);
        end
        nb = (len + BS - 1) / BS;
        checks++;
        if (wr_log.size() != nb) begin
            errors++;
            $display("FAIL %s write count: got %0d want %0d", name, wr_log.size(), nb);
        end
        for (int b = 0; b < nb && b < wr_log.size(); b++) begin
            sz = (len - b * BS < BS) ? len - b * BS : BS;
            exp_addr = addr + AW'(b * BS);
            exp_data = '0;
            for (int k = 0; k < sz; k++) exp_data[(BS-k)*SIZE-1 -: SIZE] = elems[b*BS+k];
            checks++;
            if (wr_log[b].addr !== exp_addr || wr_log[b].size != sz || wr_log[b].data !== exp_data
                || wr_log[b].cyc != acc_cyc[b*BS+sz-1] + 1) begin
                errors++;
                $display("FAIL %s write %0d: addr %h size %0d cyc %0d data %h want addr %h size %0d cyc %0d data %h",
                         name, b, wr_log[b].addr, wr_log[b].size, wr_log[b].cyc, wr_log[b].data,
                         exp_addr, sz, acc_cyc[b*BS+sz-1] + 1, exp_data);
            end
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (o_req_ready !== 1'b1 || o_elem_ready !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 ||
            o_wr_en !== 1'b0 || o_wr_size !== '0 || o_addr_w !== '0 || o_data_w !== '0) begin
            errors++;
            $display("FAIL %s: rdy %b erdy %b busy %b done %b wr_en %b size %0d addr %h data %h want 1 0 0 0 0 0 0 0",
                     name, o_req_ready, o_elem_ready, o_busy, o_done, o_wr_en, o_wr_size, o_addr_w, o_data_w);
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        check_reset_outputs("reset_values");
        i_rst_n = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic test_full_blocks();
        elems.delete();
        for (int i = 1; i <= 10; i++) elems.push_back(SIZE'(i));
        do_request(24'h10, 10, 0, "full_blocks");
    endtask

    task automatic test_partial_tail();
        fill_random(7);
        do_request(24'h20, 7, 0, "partial_tail");
        for (int a = 0; a < 7; a++) begin
            checks++;
            if (!mem.exists(32'h20 + a) || mem[32'h20 + a] !== elems[a]) begin
                errors++;
                $display("FAIL partial_tail readback %h: got %h want %h", 32'h20 + a,
                         mem.exists(32'h20 + a) ? mem[32'h20 + a] : 'x, elems[a]);
            end
        end
    endtask

    task automatic test_zero_len();
        elems.delete();
        do_request(24'h123, 0, 0, "zero_len");
    endtask

    task automatic test_stalled();
        fill_random(5);
        do_request(24'h40, 5, 1, "stalled");
    endtask

    task automatic test_wrap();
        fill_random(5);
        do_request(24'hFFFFFD, 5, 0, "wrap_a");
        fill_random(8);
        do_request(24'hFFFFFE, 8, 0, "wrap_b");
    endtask

    task automatic test_reset_mid();
        wr_log.delete();
        fill_random(5);
        i_req_valid = 1'b1; i_req_addr = 24'h55; i_req_len = 16'd5;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_elem_valid = 1'b1; i_elem_data = elems[i];
            @(negedge i_clk);
        end
        i_elem_valid = 1'b0;
        i_rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_async");
        repeat (3) @(negedge i_clk);
        check_reset_outputs("reset_mid_held");
        checks++;
        if (wr_log.size() != 0) begin
            errors++;
            $display("FAIL reset_mid writes: got %0d want 0", wr_log.size());
        end
        i_rst_n = 1'b1;
        @(negedge i_clk);
        fill_random(5);
        do_request(24'h60, 5, 0, "reset_mid_after");
    endtask

    task automatic test_back_to_back();
        int prev_t, prev_len, len;
        prev_t = -1; prev_len = 0;
        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(1, 12);
            fill_random(len);
            do_request(AW'($urandom), len, 0, "back_to_back");
            if (prev_t >= 0) begin
                checks++;
                if (last_req_cyc - prev_t != prev_len + 2) begin
                    errors++;
                    $display("FAIL back_to_back spacing: got %0d want %0d", last_req_cyc - prev_t, prev_len + 2);
                end
            end
            prev_t = last_req_cyc;
            prev_len = len;
        end
    endtask

    task automatic test_random();
        int len;
        for (int r = 0; r < 25; r++) begin
            len = $urandom_range(0, 13);
            fill_random(len);
            do_request(AW'($urandom), len, 2, "random");
            repeat ($urandom_range(0, 2)) @(negedge i_clk);
        end
    endtask

    initial begin
        test_reset();
        test_full_blocks();
        test_partial_tail();
        test_zero_len();
        test_stalled();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
